// File: rtl/srl_sra_seq_32bit.sv
`default_nettype none
// ============================================================================
// Module   : srl_sra_seq_32bit
// Brief    : Multi-cycle 32-bit logical/arithmetic right shifter that shifts
//            up to STEP bit positions per clock behind a start/busy/done
//            handshake.
// Revision : 1.0 - initial release
// ============================================================================
module srl_sra_seq_32bit #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] shift,
  input  logic        arith,
  output logic        busy,
  output logic        done,
  output logic [31:0] z
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_shift = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;
  localparam logic [5:0] c_step  = STEP[5:0];

  logic [1:0]  r_state;
  logic [31:0] r_acc;
  logic [4:0]  r_rem;
  logic        r_fill;
  logic [31:0] r_z;
  logic        r_busy;
  logic        r_done;

  logic [5:0]  w_rem_ext;
  logic [5:0]  w_k;
  logic [31:0] w_acc_next;
  logic [4:0]  w_rem_next;
  logic        w_unused;

  // Only the low five bits form the shift amount; the rest are don't-care.
  assign w_unused   = ^shift[31:5];

  assign w_rem_ext  = {1'b0, r_rem};
  assign w_k        = (w_rem_ext >= c_step) ? c_step : w_rem_ext;
  assign w_acc_next = 32'({{32{r_fill}}, r_acc} >> w_k);
  assign w_rem_next = 5'(w_rem_ext - w_k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_acc   <= 32'd0;
      r_rem   <= 5'd0;
      r_fill  <= 1'b0;
      r_z     <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_shift: begin
          if (r_rem == 5'd0) begin
            r_z     <= r_acc;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= c_done;
          end else begin
            r_acc <= w_acc_next;
            r_rem <= w_rem_next;
          end
        end
        // IDLE and DONE both accept a request, which gives back-to-back issue.
        default: begin
          if (start) begin
            r_acc   <= x;
            r_rem   <= shift[4:0];
            r_fill  <= arith & x[31];
            r_busy  <= 1'b1;
            r_state <= c_shift;
          end else begin
            r_busy  <= 1'b0;
            r_state <= c_idle;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign z    = r_z;

endmodule
`default_nettype wire
